// File: rtl/port_requester.sv
// Input-port side of the output-port arbitration handshake: requests the SOP's
// destination port, backs off on refusal/timeout, and streams the packet on grant.
module port_requester #(
  parameter int NUM_PORTS   = 16,
  parameter int DATA_W      = 32,
  parameter int DEST_W      = 4,
  parameter int BACKOFF_CYC = 8,
  parameter int REQ_TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pkt_valid,
  input  logic                 i_pkt_sop,
  input  logic                 i_pkt_eop,
  input  logic [DEST_W-1:0]    i_pkt_dest,
  input  logic [DATA_W-1:0]    i_pkt_data,
  output logic                 o_pkt_ready,
  input  logic [NUM_PORTS-1:0] i_port_ready,
  output logic [NUM_PORTS-1:0] o_req,
  input  logic [NUM_PORTS-1:0] i_resp,
  input  logic [NUM_PORTS-1:0] i_nresp,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_valid,
  output logic                 o_eop,
  output logic                 o_timeout,
  output logic                 o_err
);

  // state   | meaning
  // S_IDLE  | waiting for an SOP whose output port is ready
  // S_REQ   | o_req held, waiting for resp/nresp or timeout
  // S_XFER  | granted, streaming beats while resp stays high
  // S_BACKOFF | o_req dropped, counting down before re-requesting
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_BACKOFF} state_t;

  localparam int TMO_W = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
  localparam int BO_W  = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(REQ_TIMEOUT - 1);
  // Loading N-1 and leaving at zero gives exactly N cycles with o_req low.
  localparam logic [BO_W-1:0]      BO_LOAD  = BO_W'(BACKOFF_CYC - 1);
  localparam logic [NUM_PORTS-1:0] ONE      = NUM_PORTS'(1);

  state_t                r_state;
  logic [DEST_W-1:0]     r_dest;
  logic [TMO_W-1:0]      r_tmo_cnt;
  logic [BO_W-1:0]       r_bo_cnt;
  logic [NUM_PORTS-1:0]  r_req;
  logic [DATA_W-1:0]     r_data;
  logic                  r_valid;
  logic                  r_eop;
  logic                  r_timeout;

  logic [NUM_PORTS-1:0]  w_dest_oh;
  logic [NUM_PORTS-1:0]  w_in_oh;
  logic                  w_in_rdy;
  logic                  w_port_rdy;
  logic                  w_resp;
  logic                  w_nresp;
  logic                  w_drop;
  logic                  w_accept;

  assign w_dest_oh  = ONE << r_dest;
  assign w_in_oh    = ONE << i_pkt_dest;
  assign w_in_rdy   = |(i_port_ready & w_in_oh);
  assign w_port_rdy = |(i_port_ready & w_dest_oh);
  assign w_resp     = |(i_resp & w_dest_oh);
  assign w_nresp    = |(i_nresp & w_dest_oh);

  assign w_drop   = !i_rst && (r_state == S_IDLE) && i_pkt_valid && !i_pkt_sop;
  assign w_accept = !i_rst && (r_state == S_XFER) && w_resp && i_pkt_valid;

  assign o_pkt_ready = w_drop || (!i_rst && (r_state == S_XFER) && w_resp);
  assign o_err       = w_drop;
  assign o_req       = r_req;
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_eop       = r_eop;
  assign o_timeout   = r_timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_dest    <= '0;
      r_tmo_cnt <= '0;
      r_bo_cnt  <= '0;
      r_req     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_eop     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_eop     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_pkt_valid && i_pkt_sop && w_in_rdy) begin
            r_dest    <= i_pkt_dest;
            r_req     <= w_in_oh;
            r_tmo_cnt <= '0;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_resp) begin
            r_state <= S_XFER;
          end else if (w_nresp) begin
            r_req    <= '0;
            r_bo_cnt <= BO_LOAD;
            r_state  <= S_BACKOFF;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_timeout <= 1'b1;
            r_req     <= '0;
            r_bo_cnt  <= BO_LOAD;
            r_state   <= S_BACKOFF;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_XFER: begin
          if (w_accept) begin
            r_data  <= i_pkt_data;
            r_valid <= 1'b1;
            if (i_pkt_eop) begin
              r_eop   <= 1'b1;
              r_req   <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        S_BACKOFF: begin
          if (r_bo_cnt != '0) begin
            r_bo_cnt <= r_bo_cnt - 1'b1;
          end else if (w_port_rdy) begin
            r_req     <= w_dest_oh;
            r_tmo_cnt <= '0;
            r_state   <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/port_requester.md
Name: port_requester

Overview:
- Input-port side of the output-port arbitration handshake; one instance per input port.
- Takes packets from the input-port buffer and reads the destination port from the SOP beat.
- Raises a one-hot request toward that output port's arbitrator and waits for grant (resp) or refusal (nresp).
- On grant, streams the packet to the crossbar and signals end-of-packet so the arbitrator can release the port.

Parameters:
- NUM_PORTS, 16, number of output ports / width of request and response vectors.
- DATA_W, 32, packet beat width.
- DEST_W, 4, destination index width; must equal log2(NUM_PORTS).
- BACKOFF_CYC, 8, wait cycles after nresp or timeout before re-requesting.
- REQ_TIMEOUT, 64, cycles in REQ without resp/nresp before abandoning the attempt.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_pkt_valid  in  1  upstream beat valid.
- i_pkt_sop  in  1  beat is first of packet.
- i_pkt_eop  in  1  beat is last of packet.
- i_pkt_dest  in  DEST_W  destination output port; sampled only on SOP beat.
- i_pkt_data  in  DATA_W  beat payload.
- o_pkt_ready  out  1  upstream beat accepted when valid&ready.
- i_port_ready  in  NUM_PORTS  per-output-port arbitrator ready.
- o_req  out  NUM_PORTS  one-hot request; bit k targets output port k.
- i_resp  in  NUM_PORTS  grant from arbitrator k to this input.
- i_nresp  in  NUM_PORTS  refusal from arbitrator k to this input.
- o_data  out  DATA_W  beat to crossbar.
- o_valid  out  1  o_data valid.
- o_eop  out  1  last beat of granted packet; coincident with o_valid.
- o_timeout  out  1  one-cycle pulse when REQ_TIMEOUT expires.
- o_err  out  1  one-cycle pulse when a non-SOP beat is dropped in IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, dest register 0, counters 0. Reset asserted mid-transfer aborts immediately; o_req/o_valid/o_eop are 0 the next cycle; the partial packet is not completed.
- State IDLE:
  - o_pkt_ready=0 except for an error drop.
  - valid&sop&i_port_ready[dest]: latch dest, go REQ; o_req[dest]=1 from the next cycle. The SOP beat is not consumed.
  - valid&sop&!i_port_ready[dest]: stay IDLE.
  - valid&!sop: pulse o_pkt_ready=1 and o_err=1 that cycle, discarding the beat.
- State REQ:
  - o_req=onehot(dest) held; timeout counter increments each cycle.
  - i_resp[dest]=1 goes XFER next cycle, including when i_nresp[dest] is also 1 (resp wins).
  - i_nresp[dest]=1 alone: o_req cleared next cycle, load BACKOFF_CYC, go BACKOFF.
  - Counter reaches REQ_TIMEOUT-1 with no response: o_timeout pulse, o_req cleared, go BACKOFF.
  - resp/nresp bits for ports other than dest are ignored.
- State XFER:
  - o_req held; o_pkt_ready = i_resp[dest].
  - Accepted beat registered to o_data/o_valid with 1-cycle latency.
  - If i_resp[dest] drops mid-packet: o_pkt_ready=0 and o_valid=0 until it returns. This is a stall, not an abort.
  - A beat with i_pkt_eop accepted: next cycle o_valid=1, o_eop=1 and o_req cleared in that same cycle. State returns to IDLE.
  - A new SOP may be evaluated in the cycle after o_eop.
  - i_pkt_sop seen on a non-first beat is ignored as data.
- State BACKOFF:
  - o_req=0; counter decrements to 0.
  - At 0 with i_port_ready[dest]=1: re-enter REQ, dest unchanged, timeout counter cleared.
  - At 0 with i_port_ready[dest]=0: hold.
- o_req is never multi-hot and is never asserted outside REQ/XFER.
- Single-beat packet (sop&eop): one o_valid cycle with o_eop=1.

Test Plan:
- Reset then SOP dest=1, i_port_ready=16'hFFFF, resp[1] 2 cycles after o_req -> o_req=16'h0002; 3-beat packet 0xA,0xB,0xC appears on o_data in 3 consecutive cycles; o_eop with 0xC; o_req=0 in the o_eop cycle.
- SOP dest=15, nresp[15] after 1 cycle -> o_req=0 for 8 cycles, then o_req=16'h8000 again; grant then completes the packet normally.
- SOP dest=3, no response -> o_req=16'h0008 for 64 cycles, o_timeout pulse, 8-cycle backoff, re-request.
- Grant on port 5, resp[5] deasserted for 3 cycles mid-packet -> o_pkt_ready=0 and o_valid=0 for those cycles; no beat lost or duplicated.
- Simultaneous resp[2]&nresp[2] -> XFER taken. Non-SOP beat in IDLE -> o_err pulse, beat dropped.
- i_rst=1 during XFER beat 2 of 4 -> next cycle o_req=0, o_valid=0, state IDLE.
